// File: rtl/l2_mem_responder.sv
// l2_mem_responder
//   Line-granular memory responder sitting on the L2 cache's memory-request
//   interface. Each accepted request reads or writes one full cache line of
//   an internal SRAM array. The response is returned after a programmable
//   number of wait cycles. Only one transaction is outstanding at a time.
//
// Parameters
//   abits    log2 of the number of lines held in the array
//   latency  extra wait cycles between accept and response (clamped to 15)
//
// Ports
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_req_mem_valid  request valid
//   i_req_mem_type   bit0 WRITE, bit1 CACHED, bit2 UNIQUE
//   i_req_mem_size   log2 access bytes (informational only)
//   i_req_mem_prot   protection attributes (captured, not checked)
//   i_req_mem_addr   byte address
//   i_req_mem_strob  write byte enables, one per byte of the line
//   i_req_mem_data   write line data
//   o_req_mem_ready  request may be accepted this cycle
//   o_mem_data_valid one-cycle response strobe (read data or write ack)
//   o_mem_data       read line data; zero on write ack and on error
//   o_mem_data_err   response carries an out-of-range error
module l2_mem_responder #(
   parameter int unsigned abits   = 10,
   parameter int unsigned latency = 2,
   localparam int unsigned REQ_MEM_TYPE_BITS          = 3,
   localparam int unsigned CFG_CPU_ADDR_BITS          = 48,
   localparam int unsigned CFG_L2_LOG2_BYTES_PER_LINE = 5,
   localparam int unsigned L2CACHE_BYTES_PER_LINE     = 1 << CFG_L2_LOG2_BYTES_PER_LINE,
   localparam int unsigned L2CACHE_LINE_BITS          = 8 * L2CACHE_BYTES_PER_LINE
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_req_mem_valid,
   input  logic [REQ_MEM_TYPE_BITS-1:0]      i_req_mem_type,
   input  logic [2:0]                        i_req_mem_size,
   input  logic [2:0]                        i_req_mem_prot,
   input  logic [CFG_CPU_ADDR_BITS-1:0]      i_req_mem_addr,
   input  logic [L2CACHE_BYTES_PER_LINE-1:0] i_req_mem_strob,
   input  logic [L2CACHE_LINE_BITS-1:0]      i_req_mem_data,
   output logic                              o_req_mem_ready,
   output logic                              o_mem_data_valid,
   output logic [L2CACHE_LINE_BITS-1:0]      o_mem_data,
   output logic                              o_mem_data_err
);

   localparam int unsigned DEPTH   = 1 << abits;
   localparam int unsigned IDX_LSB = CFG_L2_LOG2_BYTES_PER_LINE;
   localparam int unsigned IDX_MSB = CFG_L2_LOG2_BYTES_PER_LINE + abits - 1;
   localparam logic [3:0]  LAT     = (latency > 15) ? 4'd15 : 4'(latency);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t state;
   state_t next_state;

   logic [3:0]                        cnt;
   logic                              accept;
   logic                              req_oor;
   logic [abits-1:0]                  req_idx;

   // Captured request
   logic [REQ_MEM_TYPE_BITS-1:0]      type_q;
   logic [2:0]                        prot_q;
   logic                              wr_q;
   logic                              oor_q;
   logic [abits-1:0]                  idx_q;
   logic [L2CACHE_BYTES_PER_LINE-1:0] strob_q;
   logic [L2CACHE_LINE_BITS-1:0]      data_q;

   // Response values computed during Resp, registered onto the outputs
   logic                              resp_valid;
   logic                              resp_err;
   logic [L2CACHE_LINE_BITS-1:0]      resp_data;
   logic                              mem_we;

   logic [L2CACHE_LINE_BITS-1:0]      mem [DEPTH];

   // Attributes that do not influence behaviour
   logic unused_ok;
   assign unused_ok = ^{i_req_mem_size, i_req_mem_addr[IDX_LSB-1:0],
                        type_q[REQ_MEM_TYPE_BITS-1:1], prot_q};

   // Ready is a register, so accept is gated by the registered value rather
   // than by state; this keeps ready low for the first cycle after reset.
   assign accept  = i_req_mem_valid & o_req_mem_ready;
   assign req_idx = i_req_mem_addr[IDX_MSB:IDX_LSB];

   always_comb begin
      req_oor = 1'b0;
      for (int unsigned b = IDX_MSB + 1; b < CFG_CPU_ADDR_BITS; b++) begin
         req_oor = req_oor | i_req_mem_addr[b];
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd1) begin
               next_state = S_RESP;
            end
         end
         S_RESP: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_data  = '0;
      mem_we     = 1'b0;
      if (state == S_RESP) begin
         resp_valid = 1'b1;
         if (oor_q) begin
            resp_err = 1'b1;
         end else if (wr_q) begin
            mem_we = 1'b1;
         end else begin
            resp_data = mem[idx_q];
         end
      end
   end

   // ------------------------------------------------------ wait counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= LAT;
      end else if (state == S_WAIT) begin
         cnt <= cnt - 4'd1;
      end
   end

   // ------------------------------------------------- request capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         type_q  <= '0;
         prot_q  <= '0;
         wr_q    <= 1'b0;
         oor_q   <= 1'b0;
         idx_q   <= '0;
         strob_q <= '0;
         data_q  <= '0;
      end else if (accept) begin
         type_q  <= i_req_mem_type;
         prot_q  <= i_req_mem_prot;
         wr_q    <= i_req_mem_type[0];
         oor_q   <= req_oor;
         idx_q   <= req_idx;
         strob_q <= i_req_mem_strob;
         data_q  <= i_req_mem_data;
      end
   end

   // --------------------------------------------------- registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_req_mem_ready  <= 1'b0;
         o_mem_data_valid <= 1'b0;
         o_mem_data       <= '0;
         o_mem_data_err   <= 1'b0;
      end else begin
         o_req_mem_ready  <= (next_state == S_IDLE);
         o_mem_data_valid <= resp_valid;
         o_mem_data       <= resp_data;
         o_mem_data_err   <= resp_err;
      end
   end

   // ------------------------------------------------------------- array
   // Not reset. Reset forces state to Idle, which drops mem_we, so a reset
   // during Wait or Resp suppresses the commit.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         for (int unsigned k = 0; k < L2CACHE_BYTES_PER_LINE; k++) begin
            if (strob_q[k]) begin
               mem[idx_q][8*k +: 8] <= data_q[8*k +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_l2_mem_responder.sv
module tb_l2_mem_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         vld_a = 1'b0;
   logic         vld_b = 1'b0;
   logic [2:0]   type_s = '0;
   logic [2:0]   size_s = 3'd5;
   logic [2:0]   prot_s = '0;
   logic [47:0]  addr_s = '0;
   logic [31:0]  strob_s = '0;
   logic [255:0] data_s = '0;

   logic         rdy_a, val_a, err_a;
   logic [255:0] dat_a;
   logic         rdy_b, val_b, err_b;
   logic [255:0] dat_b;

   int pass_cnt = 0;
   int total_cnt = 0;
   time last_acc = 0;

   logic [255:0] m0 [1024];
   logic [255:0] m1 [1024];

   always #5 clk = ~clk;

   l2_mem_responder #(.abits(10), .latency(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_req_mem_valid(vld_a), .i_req_mem_type(type_s),
      .i_req_mem_size(size_s), .i_req_mem_prot(prot_s), .i_req_mem_addr(addr_s),
      .i_req_mem_strob(strob_s), .i_req_mem_data(data_s), .o_req_mem_ready(rdy_a),
      .o_mem_data_valid(val_a), .o_mem_data(dat_a), .o_mem_data_err(err_a));

   l2_mem_responder #(.abits(10), .latency(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_req_mem_valid(vld_b), .i_req_mem_type(type_s),
      .i_req_mem_size(size_s), .i_req_mem_prot(prot_s), .i_req_mem_addr(addr_s),
      .i_req_mem_strob(strob_s), .i_req_mem_data(data_s), .o_req_mem_ready(rdy_b),
      .o_mem_data_valid(val_b), .o_mem_data(dat_b), .o_mem_data_err(err_b));

   typedef struct {
      int           sel;
      bit           wr;
      logic [47:0]  addr;
      logic [31:0]  strob;
      logic [255:0] wdata;
      logic [255:0] exp_d;
      bit           exp_e;
      string        name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   function automatic logic sel_rdy(input int sel);
      return (sel == 0) ? rdy_a : rdy_b;
   endfunction

   function automatic logic sel_val(input int sel);
      return (sel == 0) ? val_a : val_b;
   endfunction

   task automatic set_vld(input int sel, input logic v);
      if (sel == 0) vld_a = v;
      else vld_b = v;
   endtask

   // Reference: line index and range from the address, byte-merge writes.
   task automatic model_op(input int sel, input bit wr, input logic [47:0] a,
                           input logic [31:0] s, input logic [255:0] w,
                           output logic [255:0] d, output bit e);
      int idx;
      logic [255:0] line;
      idx = int'(a[14:5]);
      line = (sel == 0) ? m0[idx] : m1[idx];
      d = '0;
      e = 1'b0;
      if ((a >> 15) != 48'd0) begin
         e = 1'b1;
      end else if (wr) begin
         for (int k = 0; k < 32; k++) if (s[k]) line[8*k +: 8] = w[8*k +: 8];
         if (sel == 0) m0[idx] = line;
         else m1[idx] = line;
      end else begin
         d = line;
      end
   endtask

   function automatic logic [255:0] rnd_line();
      logic [255:0] w;
      for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
      return w;
   endfunction

   // Called at a negedge. Waits for ready, issues one request, checks the
   // response latency (counted in negedges after the accept edge), data, err.
   task automatic txn(input int sel, input bit wr, input logic [47:0] a,
                      input logic [31:0] s, input logic [255:0] w,
                      input bit use_exp, input logic [255:0] exp_d, input bit exp_e,
                      input string name);
      int lat;
      int n;
      bit got;
      logic [255:0] md;
      bit me;
      lat = (sel == 0) ? 2 : 0;
      model_op(sel, wr, a, s, w, md, me);
      if (use_exp) begin
         md = exp_d;
         me = exp_e;
      end
      n = 0;
      while (sel_rdy(sel) !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         chk({name, "_ready_timeout"}, 256'(sel_rdy(sel)), 256'd1);
         return;
      end
      type_s  = {$urandom_range(0, 3) == 0 ? 2'b11 : 2'b00, wr};
      prot_s  = 3'($urandom_range(0, 7));
      addr_s  = a;
      strob_s = s;
      data_s  = w;
      set_vld(sel, 1'b1);
      @(posedge clk);
      last_acc = $time;
      @(negedge clk);
      // Junk request while not ready must be ignored
      addr_s  = 48'h40;
      strob_s = '1;
      data_s  = rnd_line();
      type_s  = 3'b001;
      n = 1;
      got = 0;
      while (!got && n <= 40) begin
         if (n >= 2) set_vld(sel, 1'b0);
         if (sel_val(sel) === 1'b1) got = 1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      set_vld(sel, 1'b0);
      chk({name, "_latency"}, 256'(got ? n : 0), 256'(lat + 2));
      if (got) begin
         chk({name, "_data"}, (sel == 0) ? dat_a : dat_b, md);
         chk({name, "_err"}, 256'((sel == 0) ? err_a : err_b), 256'(me));
      end
   endtask

   task automatic add_vec(input int sel, input bit wr, input logic [47:0] a,
                          input logic [31:0] s, input logic [255:0] w,
                          input logic [255:0] ed, input bit ee, input string nm);
      vec_t v;
      v.sel = sel; v.wr = wr; v.addr = a; v.strob = s; v.wdata = w;
      v.exp_d = ed; v.exp_e = ee; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin : main
      logic [255:0] pa5, p5c, pff, p77, p3c, pee, part, partexp;
      time t1, t2, t3;
      int sel, n;
      bit wr;
      logic [47:0] a;
      logic [31:0] s;

      for (int i = 0; i < 1024; i++) begin
         m0[i] = '0;
         m1[i] = '0;
      end
      pa5 = {32{8'hA5}};
      p5c = {32{8'h5C}};
      pff = {32{8'hFF}};
      p77 = {32{8'h77}};
      p3c = {32{8'h3C}};
      pee = {32{8'hEE}};
      part = {{28{8'hEE}}, 32'h11223344};
      partexp = {p5c[255:32], 32'h11223344};

      add_vec(0, 0, 48'h0,    32'h0,        '0,   '0,      0, "rd_line0");
      add_vec(0, 1, 48'h40,   32'hFFFFFFFF, pa5,  '0,      0, "wr_40");
      add_vec(0, 0, 48'h40,   32'h0,        '0,   pa5,     0, "rd_40");
      add_vec(0, 0, 48'h47,   32'h0,        '0,   pa5,     0, "rd_47");
      add_vec(0, 1, 48'h80,   32'hFFFFFFFF, p5c,  '0,      0, "wr_80_full");
      add_vec(0, 1, 48'h80,   32'h0000000F, part, '0,      0, "wr_80_part");
      add_vec(0, 0, 48'h80,   32'h0,        '0,   partexp, 0, "rd_80");
      add_vec(0, 1, 48'h8000, 32'hFFFFFFFF, pff,  '0,      1, "wr_oor");
      add_vec(0, 0, 48'h8000, 32'h0,        '0,   '0,      1, "rd_oor");
      add_vec(0, 0, 48'h0,    32'h0,        '0,   '0,      0, "rd_line0_again");
      add_vec(0, 1, 48'h60,   32'h0,        pff,  '0,      0, "wr_60_nostrb");
      add_vec(0, 0, 48'h60,   32'h0,        '0,   '0,      0, "rd_60");
      add_vec(0, 1, 48'hC0,   32'hFFFFFFFF, p77,  '0,      0, "wr_c0");
      add_vec(1, 0, 48'h20,   32'h0,        '0,   '0,      0, "l0_rd_20");
      add_vec(1, 1, 48'h20,   32'hFFFFFFFF, p3c,  '0,      0, "l0_wr_20");
      add_vec(1, 0, 48'h20,   32'h0,        '0,   p3c,     0, "l0_rd_20b");

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 256'(rdy_a), 256'd0);
      chk("rst_valid", 256'(val_a), 256'd0);
      chk("rst_data", dat_a, '0);
      chk("rst_err", 256'(err_a), 256'd0);
      rst = 1'b0;
      #1 chk("ready_before_edge", 256'(rdy_a), 256'd0);
      @(negedge clk);
      chk("ready_after_release", 256'(rdy_a), 256'd1);

      // Directed table
      foreach (vecs[i]) begin
         txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].strob, vecs[i].wdata,
             1, vecs[i].exp_d, vecs[i].exp_e, vecs[i].name);
      end

      // latency=0 back-to-back: accept every 2 cycles
      txn(1, 0, 48'h100, '0, '0, 0, '0, 0, "b2b_rd1");
      t1 = last_acc;
      txn(1, 1, 48'h100, 32'h0000FF00, pee, 0, '0, 0, "b2b_wr");
      t2 = last_acc;
      txn(1, 0, 48'h100, '0, '0, 0, '0, 0, "b2b_rd2");
      t3 = last_acc;
      chk("b2b_gap1", 256'(t2 - t1), 256'd20);
      chk("b2b_gap2", 256'(t3 - t2), 256'd20);

      // Reset during Wait of a write to 0xC0: dropped, no response
      while (rdy_a !== 1'b1) @(negedge clk);
      type_s = 3'b001; addr_s = 48'hC0; strob_s = '1; data_s = pee;
      vld_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld_a = 1'b0;
      rst = 1'b1;
      n = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (val_a === 1'b1) n++;
      end
      chk("rst_mid_no_valid", 256'(n), 256'd0);
      chk("rst_mid_ready", 256'(rdy_a), 256'd0);
      rst = 1'b0;
      #1 chk("rst_mid_ready_edge", 256'(rdy_a), 256'd0);
      @(negedge clk);
      chk("rst_mid_ready_back", 256'(rdy_a), 256'd1);
      txn(0, 0, 48'hC0, '0, '0, 1, p77, 0, "rd_c0_after_rst");

      // Randomized traffic against the reference model
      for (int i = 0; i < 120; i++) begin
         sel = $urandom_range(0, 1);
         wr = $urandom_range(0, 1) == 1;
         a = (48'($urandom_range(0, 15)) << 5) | 48'($urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) a[$urandom_range(15, 47)] = 1'b1;
         s = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom);
         txn(sel, wr, a, s, rnd_line(), 0, '0, 0, "rand");
      end

      @(negedge clk);
      chk("idle_valid_a", 256'(val_a), 256'd0);
      chk("idle_valid_b", 256'(val_b), 256'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule
